accel_spi_tilt: RTL and testbench

Upstream stage of the MTL/Qbert display controller. It drives the DE0-Nano ADXL345 accelerometer over 4-wire SPI and configures the sensor after reset. It then reads X/Y acceleration periodically and reduces each sample to an 8-bit tilt code, oSPI, which drives the controller's iSPI input. The code is readable by the Nios at register A_iSPI and is used to steer Qbert.

---
 rtl/accel_spi_pkg.sv | 79 +++++++
 rtl/accel_spi_tilt_spi_byte_engine.sv | 72 +++++++
 rtl/accel_spi_tilt.sv | 203 ++++++++++++++++++++
 tb/tb_accel_spi_tilt.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_spi_pkg.sv
// Shared types, ADXL345 register map and tilt-reduction helpers for the
// accelerometer front end of the display controller.
package accel_spi_pkg;

    typedef enum logic [2:0] {
        ST_INIT_FMT = 3'd0,
        ST_INIT_PWR = 3'd1,
        ST_IDLE     = 3'd2,
        ST_READ     = 3'd3,
        ST_UPDATE   = 3'd4
    } state_e;

    // Progress of one chip-select frame: inter-frame gap, CS setup, byte transfer.
    typedef enum logic [1:0] {
        PH_GAP   = 2'd0,
        PH_SETUP = 2'd1,
        PH_XFER  = 2'd2
    } phase_e;

    typedef enum logic [1:0] {
        DIR_POS_X = 2'b00,
        DIR_NEG_X = 2'b01,
        DIR_POS_Y = 2'b10,
        DIR_NEG_Y = 2'b11
    } tilt_dir_e;

    localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
    localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
    localparam logic [7:0] REG_DATAX0      = 8'h32;
    localparam logic [7:0] VAL_DATA_FORMAT = 8'h00;
    localparam logic [7:0] VAL_POWER_CTL   = 8'h08;

    localparam int CMD_R_BIT  = 7;
    localparam int CMD_MB_BIT = 6;

    localparam logic [7:0] CMD_READ_XY = REG_DATAX0 | (8'd1 << CMD_R_BIT) | (8'd1 << CMD_MB_BIT);

    // Raw 16-bit sample divided by four, clamped into a signed byte.
    function automatic logic [7:0] scale_sat(input logic [15:0] raw);
        logic signed [15:0] s;
        s = $signed(raw) >>> 2;
        if (s > 16'sd127) begin
            return 8'h7F;
        end
        if (s < -16'sd128) begin
            return 8'h80;
        end
        return s[7:0];
    endfunction

    // Nine bits so that the magnitude of -128 is representable.
    function automatic logic [8:0] abs9(input logic [7:0] v);
        logic [8:0] e;
        e = {v[7], v};
        return v[7] ? (~e + 9'd1) : e;
    endfunction

    function automatic logic [7:0] tilt_code(input logic [7:0] sx,
                                             input logic [7:0] sy,
                                             input logic [7:0] thresh);
        logic [8:0] ax;
        logic [8:0] ay;
        logic [8:0] dom;
        logic [4:0] mag;
        tilt_dir_e  dir;
        ax = abs9(sx);
        ay = abs9(sy);
        if (ay > ax) begin
            dom = ay;
            dir = sy[7] ? DIR_NEG_Y : DIR_POS_Y;
        end else begin
            dom = ax;
            dir = sx[7] ? DIR_NEG_X : DIR_POS_X;
        end
        mag = (dom[8:2] > 7'd31) ? 5'd31 : dom[6:2];
        return {(dom > {1'b0, thresh}), dir, mag};
    endfunction

endpackage

// File: rtl/accel_spi_tilt_spi_byte_engine.sv
// Mode-3 SPI byte shifter: one start moves 8 bits MSB first in 16 half-periods;
// done is asserted during the last cycle so the next byte can follow seamlessly.
module spi_byte_engine #(
    parameter int CLK_DIV = 25
) (
    input  logic       Avalon_CLK_50,
    input  logic       iRST_n,
    input  logic       start_i,
    input  logic [7:0] tx_byte_i,
    output logic [7:0] rx_byte_o,
    output logic       done_o,
    output logic       sclk_o,
    output logic       sdo_o,
    input  logic       sdi_i
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic          busy_q;
    logic [DW-1:0] div_q;
    logic [3:0]    half_q;
    logic          sclk_q;
    logic          sdo_q;
    logic [7:0]    tx_sh_q;
    logic [7:0]    rx_sh_q;

    always_ff @(posedge Avalon_CLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            busy_q  <= 1'b0;
            div_q   <= '0;
            half_q  <= 4'd0;
            sclk_q  <= 1'b1;
            sdo_q   <= 1'b0;
            tx_sh_q <= 8'h00;
            rx_sh_q <= 8'h00;
        end else if (start_i) begin
            busy_q  <= 1'b1;
            div_q   <= '0;
            half_q  <= 4'd0;
            sclk_q  <= 1'b0;
            sdo_q   <= tx_byte_i[7];
            tx_sh_q <= {tx_byte_i[6:0], 1'b0};
        end else if (busy_q) begin
            if (div_q == DIV_LAST) begin
                div_q <= '0;
                if (half_q == 4'd15) begin
                    busy_q <= 1'b0;
                end else begin
                    half_q <= half_q + 4'd1;
                    // Even half-periods are low: leaving one is a rising edge.
                    if (!half_q[0]) begin
                        sclk_q  <= 1'b1;
                        rx_sh_q <= {rx_sh_q[6:0], sdi_i};
                    end else begin
                        sclk_q  <= 1'b0;
                        sdo_q   <= tx_sh_q[7];
                        tx_sh_q <= {tx_sh_q[6:0], 1'b0};
                    end
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    assign done_o    = busy_q && (half_q == 4'd15) && (div_q == DIV_LAST);
    assign rx_byte_o = rx_sh_q;
    assign sclk_o    = sclk_q;
    assign sdo_o     = sdo_q;

endmodule

// File: rtl/accel_spi_tilt.sv
// ADXL345 front end: configures the sensor, polls X/Y periodically and reduces
// each sample to the 8-bit tilt code consumed by the display controller.
module accel_spi_tilt
    import accel_spi_pkg::*;
#(
    parameter int         CLK_DIV       = 25,
    parameter int         SAMPLE_PERIOD = 500000,
    parameter logic [7:0] TILT_THRESH   = 8'd40
) (
    input  logic       Avalon_CLK_50,
    input  logic       iRST_n,
    output logic       oSPI_CS_n,
    output logic       oSPI_SCLK,
    output logic       oSPI_SDO,
    input  logic       iSPI_SDI,
    output logic [7:0] oACC_X,
    output logic [7:0] oACC_Y,
    output logic [7:0] oSPI,
    output logic       oValid,
    output logic       oBusy
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = $clog2(2 * CLK_DIV);
    localparam int TW = $clog2(SAMPLE_PERIOD + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(2 * CLK_DIV - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(SAMPLE_PERIOD - 1);

    state_e         state_q, state_d;
    phase_e         phase_q, phase_d;
    logic [2:0]     byte_q, byte_d;
    logic [DW-1:0]  cnt_q, cnt_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic           cs_q, cs_d;
    logic [7:0]     accx_q, accx_d;
    logic [7:0]     accy_q, accy_d;
    logic [7:0]     spi_q, spi_d;
    logic           valid_q, valid_d;
    logic [3:0][7:0] rx_q;
    logic           rx_we;
    logic [2:0]     frame_last;

    logic           eng_start;
    logic           eng_done;
    logic [7:0]     eng_tx;
    logic [7:0]     eng_rx;
    logic           eng_sclk;
    logic           eng_sdo;

    logic [7:0]     sx;
    logic [7:0]     sy;
    logic [7:0]     code;

    spi_byte_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .Avalon_CLK_50 (Avalon_CLK_50),
        .iRST_n        (iRST_n),
        .start_i       (eng_start),
        .tx_byte_i     (eng_tx),
        .rx_byte_o     (eng_rx),
        .done_o        (eng_done),
        .sclk_o        (eng_sclk),
        .sdo_o         (eng_sdo),
        .sdi_i         (iSPI_SDI)
    );

    // rx_q holds X0, X1, Y0, Y1; the command byte's echo is not kept.
    assign sx   = scale_sat({rx_q[1], rx_q[0]});
    assign sy   = scale_sat({rx_q[3], rx_q[2]});
    assign code = tilt_code(sx, sy, TILT_THRESH);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        byte_d    = byte_q;
        cnt_d     = cnt_q;
        cs_d      = cs_q;
        accx_d    = accx_q;
        accy_d    = accy_q;
        spi_d     = spi_q;
        valid_d   = 1'b0;
        eng_start = 1'b0;
        rx_we     = 1'b0;
        eng_tx    = 8'h00;
        gap_d     = !cs_q ? '0 : ((gap_q == GAP_LAST) ? gap_q : gap_q + 1'b1);
        // Timer parks at its last value, which doubles as the pending-sample flag.
        tmr_d      = (tmr_q == TMR_LAST) ? tmr_q : tmr_q + 1'b1;
        frame_last = (state_q == ST_READ) ? 3'd4 : 3'd1;

        case (state_q)
            ST_INIT_FMT, ST_INIT_PWR, ST_READ: begin
                case (phase_q)
                    PH_GAP: begin
                        if (gap_q == GAP_LAST) begin
                            cs_d    = 1'b0;
                            cnt_d   = '0;
                            byte_d  = 3'd0;
                            phase_d = PH_SETUP;
                        end
                    end
                    PH_SETUP: begin
                        if (cnt_q == DIV_LAST) begin
                            eng_start = 1'b1;
                            phase_d   = PH_XFER;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    PH_XFER: begin
                        if (eng_done) begin
                            rx_we = 1'b1;
                            if (byte_q == frame_last) begin
                                cs_d    = 1'b1;
                                phase_d = PH_GAP;
                                byte_d  = 3'd0;
                                case (state_q)
                                    ST_INIT_FMT: state_d = ST_INIT_PWR;
                                    ST_INIT_PWR: begin
                                        state_d = ST_IDLE;
                                        tmr_d   = TMR_LAST;
                                    end
                                    default:     state_d = ST_UPDATE;
                                endcase
                            end else begin
                                byte_d    = byte_q + 3'd1;
                                eng_start = 1'b1;
                            end
                        end
                    end
                    default: phase_d = PH_GAP;
                endcase
            end
            ST_IDLE: begin
                if (tmr_q == TMR_LAST) begin
                    state_d = ST_READ;
                    phase_d = PH_GAP;
                    tmr_d   = '0;
                end
            end
            ST_UPDATE: begin
                accx_d  = sx;
                accy_d  = sy;
                spi_d   = code;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_INIT_FMT;
        endcase

        case (state_q)
            ST_INIT_FMT: eng_tx = (byte_d == 3'd0) ? REG_DATA_FORMAT : VAL_DATA_FORMAT;
            ST_INIT_PWR: eng_tx = (byte_d == 3'd0) ? REG_POWER_CTL : VAL_POWER_CTL;
            default:     eng_tx = (byte_d == 3'd0) ? CMD_READ_XY : 8'h00;
        endcase
    end

    always_ff @(posedge Avalon_CLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= ST_INIT_FMT;
            phase_q <= PH_GAP;
            byte_q  <= 3'd0;
            cnt_q   <= '0;
            gap_q   <= '0;
            tmr_q   <= '0;
            cs_q    <= 1'b1;
            accx_q  <= 8'h00;
            accy_q  <= 8'h00;
            spi_q   <= 8'h00;
            valid_q <= 1'b0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            byte_q  <= byte_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            tmr_q   <= tmr_d;
            cs_q    <= cs_d;
            accx_q  <= accx_d;
            accy_q  <= accy_d;
            spi_q   <= spi_d;
            valid_q <= valid_d;
            for (int i = 1; i <= 4; i++) begin
                if (rx_we && (byte_q == 3'(i))) begin
                    rx_q[i-1] <= eng_rx;
                end
            end
        end
    end

    assign oSPI_CS_n = cs_q;
    assign oSPI_SCLK = eng_sclk;
    assign oSPI_SDO  = eng_sdo;
    assign oACC_X    = accx_q;
    assign oACC_Y    = accy_q;
    assign oSPI      = spi_q;
    assign oValid    = valid_q;
    assign oBusy     = !cs_q || (state_q == ST_INIT_FMT) || (state_q == ST_INIT_PWR);

endmodule

// File: tb/tb_accel_spi_tilt.sv
// Bench for accel_spi_tilt with a behavioural ADXL345 on the SPI pins and an
// arithmetic reference for the scaled values and tilt code.
module tb_accel_spi_tilt;

    localparam int CLK_DIV       = 2;
    localparam int SAMPLE_PERIOD = 400;
    localparam int THRESH        = 40;

    logic       Avalon_CLK_50 = 1'b0;
    logic       iRST_n        = 1'b0;
    logic       iSPI_SDI      = 1'b0;
    logic       oSPI_CS_n;
    logic       oSPI_SCLK;
    logic       oSPI_SDO;
    logic [7:0] oACC_X;
    logic [7:0] oACC_Y;
    logic [7:0] oSPI;
    logic       oValid;
    logic       oBusy;

    accel_spi_tilt #(
        .CLK_DIV       (CLK_DIV),
        .SAMPLE_PERIOD (SAMPLE_PERIOD),
        .TILT_THRESH   (8'd40)
    ) dut (
        .Avalon_CLK_50 (Avalon_CLK_50),
        .iRST_n        (iRST_n),
        .oSPI_CS_n     (oSPI_CS_n),
        .oSPI_SCLK     (oSPI_SCLK),
        .oSPI_SDO      (oSPI_SDO),
        .iSPI_SDI      (iSPI_SDI),
        .oACC_X        (oACC_X),
        .oACC_Y        (oACC_Y),
        .oSPI          (oSPI),
        .oValid        (oValid),
        .oBusy         (oBusy)
    );

    always #5 Avalon_CLK_50 = ~Avalon_CLK_50;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Sensor model state
    logic [15:0] mdl_x = 16'h0064;
    logic [15:0] mdl_y = 16'hFFF0;
    logic [39:0] cur;
    logic [39:0] resp;
    int          in_bits;
    int          out_idx;
    bit          is_read;
    int          fall_cyc;
    int          rise_cyc;
    bit          have_rise;
    logic        cs_prev   = 1'b1;
    logic        sclk_prev = 1'b1;
    int          frames_len[$];
    logic [39:0] frames_dat[$];
    int          gaps[$];
    int          read_starts[$];

    initial forever begin
        @(posedge Avalon_CLK_50);
        cyc = cyc + 1;
    end

    // ADXL345 model, sampled between clock edges: shifts MOSI on SCLK rise,
    // presents the next MISO bit after each SCLK fall.
    initial begin
        cur = '0; resp = '0; in_bits = 0; out_idx = 0; is_read = 0;
        fall_cyc = 0; rise_cyc = 0; have_rise = 0;
        forever begin
            @(negedge Avalon_CLK_50);
            if (cs_prev && !oSPI_CS_n) begin
                in_bits  = 0;
                out_idx  = 0;
                cur      = '0;
                is_read  = 0;
                fall_cyc = cyc;
                resp     = {8'h00, mdl_x[7:0], mdl_x[15:8], mdl_y[7:0], mdl_y[15:8]};
                if (have_rise) gaps.push_back(fall_cyc - rise_cyc);
            end else if (!oSPI_CS_n) begin
                if (sclk_prev && !oSPI_SCLK) begin
                    if (out_idx < 40) iSPI_SDI = resp[39 - out_idx];
                    out_idx = out_idx + 1;
                end
                if (!sclk_prev && oSPI_SCLK) begin
                    cur     = {cur[38:0], oSPI_SDO};
                    in_bits = in_bits + 1;
                    if (in_bits == 8) is_read = (cur[7:0] == 8'hF2);
                end
            end
            if (!cs_prev && oSPI_CS_n) begin
                frames_len.push_back(in_bits / 8);
                frames_dat.push_back(cur);
                rise_cyc  = cyc;
                have_rise = 1;
                if (in_bits == 40 && cur[39:32] == 8'hF2) read_starts.push_back(fall_cyc);
            end
            cs_prev   = oSPI_CS_n;
            sclk_prev = oSPI_SCLK;
        end
    end

    // Reference: divide by four rounding toward minus infinity, then clamp.
    function automatic int ref_scaled(input logic [15:0] r);
        int v;
        int q;
        v = $signed(r);
        q = v / 4;
        if (v < 0 && (v % 4) != 0) q = q - 1;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    function automatic int ref_code(input int sx, input int sy);
        int ax;
        int ay;
        int dom;
        int dir;
        int mag;
        ax = (sx < 0) ? -sx : sx;
        ay = (sy < 0) ? -sy : sy;
        if (ay > ax) begin
            dom = ay;
            dir = (sy < 0) ? 3 : 2;
        end else begin
            dom = ax;
            dir = (sx < 0) ? 1 : 0;
        end
        mag = dom / 4;
        if (mag > 31) mag = 31;
        return ((dom > THRESH) ? 128 : 0) + dir * 32 + mag;
    endfunction

    task automatic wait_valid(output bit ok, output int vcyc);
        ok   = 0;
        vcyc = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge Avalon_CLK_50);
            if (oValid === 1'b1) begin
                ok   = 1;
                vcyc = cyc;
            end
        end
    endtask

    task automatic test_reset;
        #23;
        checks += 7;
        if (oSPI_CS_n !== 1'b1) begin failures++; $display("FAIL reset_cs got=%b want=1", oSPI_CS_n); end
        if (oSPI_SCLK !== 1'b1) begin failures++; $display("FAIL reset_sclk got=%b want=1", oSPI_SCLK); end
        if (oSPI_SDO !== 1'b0) begin failures++; $display("FAIL reset_sdo got=%b want=0", oSPI_SDO); end
        if (oACC_X !== 8'h00) begin failures++; $display("FAIL reset_accx got=%h want=00", oACC_X); end
        if (oACC_Y !== 8'h00) begin failures++; $display("FAIL reset_accy got=%h want=00", oACC_Y); end
        if (oSPI !== 8'h00 || oValid !== 1'b0) begin
            failures++; $display("FAIL reset_spi_valid got=%h/%b want=00/0", oSPI, oValid);
        end
        if (oBusy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b want=1", oBusy); end
        $display("reset: cs=%b sclk=%b sdo=%b spi=%h busy=%b", oSPI_CS_n, oSPI_SCLK, oSPI_SDO, oSPI, oBusy);
        @(negedge Avalon_CLK_50);
        #2 iRST_n = 1'b1;
    endtask

    task automatic test_init_frames;
        int n;
        n = 0;
        while (frames_len.size() < 2 && n < 2000) begin
            @(negedge Avalon_CLK_50);
            n++;
        end
        checks++;
        if (frames_len.size() < 2) begin
            failures++;
            $display("FAIL init_frames got=%0d frames want=2 within 2000 cycles", frames_len.size());
            return;
        end
        checks += 3;
        if (frames_len[0] != 2 || frames_dat[0] !== 40'h3100) begin
            failures++; $display("FAIL init_fmt got=%0d bytes %h want=2 bytes 3100", frames_len[0], frames_dat[0]);
        end
        if (frames_len[1] != 2 || frames_dat[1] !== 40'h2D08) begin
            failures++; $display("FAIL init_pwr got=%0d bytes %h want=2 bytes 2d08", frames_len[1], frames_dat[1]);
        end
        if (gaps.size() < 1 || gaps[0] < 2 * CLK_DIV) begin
            failures++; $display("FAIL gap_fmt_pwr got=%0d want>=%0d", (gaps.size() > 0) ? gaps[0] : -1, 2 * CLK_DIV);
        end
        $display("init: frame0=%h frame1=%h", frames_dat[0], frames_dat[1]);
    endtask

    task automatic test_sample(input string name, input logic [15:0] x, input logic [15:0] y, input bit set_model);
        bit ok;
        int vcyc;
        int sx;
        int sy;
        logic [7:0] ex;
        logic [7:0] ey;
        logic [7:0] ec;
        if (set_model) begin
            mdl_x = x;
            mdl_y = y;
        end
        wait_valid(ok, vcyc);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_valid got=no pulse in 2000 cycles want=pulse", name);
            return;
        end
        sx = ref_scaled(x);
        sy = ref_scaled(y);
        ex = 8'(sx);
        ey = 8'(sy);
        ec = 8'(ref_code(sx, sy));
        checks += 4;
        if (oACC_X !== ex) begin failures++; $display("FAIL %s_accx got=%h want=%h", name, oACC_X, ex); end
        if (oACC_Y !== ey) begin failures++; $display("FAIL %s_accy got=%h want=%h", name, oACC_Y, ey); end
        if (oSPI !== ec) begin failures++; $display("FAIL %s_spi got=%h want=%h", name, oSPI, ec); end
        if (vcyc - rise_cyc != 1) begin
            failures++; $display("FAIL %s_latency got=%0d want=1 cycle after CS rise", name, vcyc - rise_cyc);
        end
        $display("sample %s: x=%h y=%h -> accx=%h accy=%h spi=%h", name, x, y, oACC_X, oACC_Y, oSPI);
        @(negedge Avalon_CLK_50);
        checks++;
        if (oValid !== 1'b0) begin failures++; $display("FAIL %s_pulse got=%b want=0 on second cycle", name, oValid); end
    endtask

    task automatic test_first_read;
        test_sample("first", 16'h0064, 16'hFFF0, 1'b0);
        checks += 2;
        if (frames_len.size() < 3 || frames_len[2] != 5 || frames_dat[2] !== 40'hF200000000) begin
            failures++;
            $display("FAIL read_frame got=%h want=f200000000", (frames_dat.size() > 2) ? frames_dat[2] : 40'h0);
        end
        if (gaps.size() < 2 || gaps[1] < 2 * CLK_DIV) begin
            failures++; $display("FAIL gap_pwr_read got=%0d want>=%0d", (gaps.size() > 1) ? gaps[1] : -1, 2 * CLK_DIV);
        end
    endtask

    task automatic test_saturation;
        test_sample("x_sat", 16'h0300, 16'h0000, 1'b1);
        test_sample("y_neg_sat", 16'h0000, 16'hFE00, 1'b1);
    endtask

    task automatic test_tie_spacing;
        int n;
        test_sample("tie", 16'h00C8, 16'h00C8, 1'b1);
        n = read_starts.size();
        checks++;
        if (n < 2 || read_starts[n-1] - read_starts[n-2] != SAMPLE_PERIOD) begin
            failures++;
            $display("FAIL read_spacing got=%0d want=%0d", (n > 1) ? read_starts[n-1] - read_starts[n-2] : -1, SAMPLE_PERIOD);
        end
    endtask

    task automatic test_random;
        logic [15:0] x;
        logic [15:0] y;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                x = 16'($urandom_range(0, 1200)) - 16'd600;
                y = 16'($urandom_range(0, 1200)) - 16'd600;
            end else begin
                x = 16'($urandom);
                y = 16'($urandom);
            end
            test_sample($sformatf("rand%0d", i), x, y, 1'b1);
        end
    endtask

    task automatic test_reset_midframe;
        int n;
        int base;
        n = 0;
        while (!(oSPI_CS_n === 1'b0 && is_read && in_bits >= 17 && in_bits <= 20) && n < 2000) begin
            @(negedge Avalon_CLK_50);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            failures++; $display("FAIL midframe_wait got=no byte-3 window want=READ byte 3 in 2000 cycles");
            return;
        end
        #2 iRST_n = 1'b0;
        #1;
        checks += 3;
        if (oSPI_CS_n !== 1'b1 || oSPI_SCLK !== 1'b1) begin
            failures++; $display("FAIL midframe_pins got=cs%b sclk%b want=cs1 sclk1", oSPI_CS_n, oSPI_SCLK);
        end
        if (oSPI !== 8'h00 || oACC_X !== 8'h00) begin
            failures++; $display("FAIL midframe_outputs got=spi%h accx%h want=00", oSPI, oACC_X);
        end
        if (oBusy !== 1'b1) begin failures++; $display("FAIL midframe_busy got=%b want=1", oBusy); end
        $display("midframe reset: cs=%b sclk=%b spi=%h", oSPI_CS_n, oSPI_SCLK, oSPI);
        repeat (3) @(negedge Avalon_CLK_50);
        #2 iRST_n = 1'b1;
        base = frames_len.size();
        n = 0;
        while (frames_len.size() <= base && n < 500) begin
            @(negedge Avalon_CLK_50);
            n++;
        end
        checks++;
        if (frames_len.size() <= base || frames_len[base] != 2 || frames_dat[base] !== 40'h3100) begin
            failures++;
            $display("FAIL rerun_init got=%h want=3100", (frames_dat.size() > base) ? frames_dat[base] : 40'h0);
        end else begin
            $display("after reset: first frame=%h", frames_dat[base]);
        end
    endtask

    initial begin
        test_reset;
        test_init_frames;
        test_first_read;
        test_saturation;
        test_tie_spacing;
        test_random;
        test_reset_midframe;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
